class_vote_accumulator: RTL and testbench
=========================================

// Module: class_vote_accumulator
// PURPOSE
//  Downstream of the neural core. Consumes one class vector per window position (calcOutput/done)
//  and keeps a saturating vote count per class over every window position of one image.
//  Drives the core's slide request between windows. After the last window it finds the class
//  with the most votes (argmax) and reports the final image classification.
// PARAMETERS
//  NUM_OUTPUT_CLASSES  10    number of classes = width of result_in
//  NUM_WINDOWS         8325  window positions per image ((200-16+1)*(60-16+1), stride 1)
//  VOTE_WIDTH          14    per-class counter width, = $clog2(NUM_WINDOWS+1)
//  CLASS_IDX_WIDTH     4     = $clog2(NUM_OUTPUT_CLASSES)
// PORTS
//  clk           in   1                   clock
//  rst           in   1                   reset, asynchronous, active-low
//  start         in   1                   1-cycle pulse: clear all votes and arm for a new image
//  result_in     in   NUM_OUTPUT_CLASSES  class vector from the core; bit i set = vote for class i
//  result_valid  in   1                   result_in valid this cycle (core done)
//  slide         out  1                   1-cycle pulse: request the next window from the core
//  busy          out  1                   high in COLLECT or SCAN
//  class_out     out  CLASS_IDX_WIDTH     winning class index
//  class_votes   out  VOTE_WIDTH          vote count of the winning class
//  no_vote       out  1                   every counter was 0 at the end of the scan
//  class_valid   out  1                   1-cycle pulse: class_out/class_votes/no_vote are final
// BEHAVIOUR
//  Reset (rst=0, takes effect at once): state=IDLE, all counters 0, and every output is 0.
//  FSM states: IDLE -> COLLECT -> SCAN -> DONE.
//   IDLE/DONE: start -> COLLECT; the same edge clears all votes and win_cnt, and sets slide=1 in the next cycle.
//   COLLECT: on each result_valid, for every set bit i, vote[i] += 1, saturating at all-ones;
//     win_cnt += 1.
//     If win_cnt+1 < NUM_WINDOWS: slide=1 in the next cycle.
//     If win_cnt+1 == NUM_WINDOWS: go to SCAN, no slide.
//     A result_in with several bits set gives one vote to each of those classes.
//     A result_in of all zeros still counts as one window.
//   SCAN: one class per cycle, idx 0..NUM_OUTPUT_CLASSES-1.
//     best is replaced only when vote[idx] > best_votes (strictly greater), so a tie goes to
//     the lowest index. After the last idx, go to DONE.
//   DONE: class_valid=1 for exactly one cycle.
//     class_out, class_votes and no_vote then hold until the next start, and reset to 0 on that start.
//  Latency: final result_valid sampled at edge T -> class_valid high in the cycle after edge
//    T+NUM_OUTPUT_CLASSES+1.
//  result_valid outside COLLECT: ignored, with no effect on counters.
//  start in COLLECT or SCAN: abort. Clear everything and restart COLLECT. No class_valid for
//    the aborted image.
//  start and result_valid in the same cycle: start wins and the result is dropped.
//  slide is never high on the same cycle as class_valid, and never high outside COLLECT.
//  win_cnt is sized $clog2(NUM_WINDOWS+1) and never wraps; it is cleared only by start or reset.
// STRUCTURE
//  The neuralcore package holds:
//    - typedef enum logic [1:0] {IDLE,COLLECT,SCAN,DONE} vote_state_t
//    - the NUM_OUTPUT_CLASSES and NUM_WINDOWS defaults
//  The vote counters form an array vote[NUM_OUTPUT_CLASSES][VOTE_WIDTH].
//  One sub-module, vote_argmax_scan, holds the SCAN-stage sequential argmax:
//    - inputs: idx, vote value
//    - outputs: best_idx, best_votes, any_nonzero
//  All other logic is in this module.
// TESTING (NUM_WINDOWS=4 and VOTE_WIDTH=3 unless noted)
//  1. Reset check: rst low mid-COLLECT -> all outputs 0 at once; after rst goes high, no
//     class_valid occurs without a new start.
//  2. Basic vote: start, then results 0x004,0x004,0x001,0x004 -> 3 slide pulses; class_out=2,
//     class_votes=3, no_vote=0; class_valid 11 cycles after the 4th result.
//  3. Tie and multi-hot: results 0x003,0x202,0x001,0x200 ->
//     votes[0]=2, votes[1]=2, votes[9]=2 -> class_out=0, class_votes=2.
//  4. Saturation and zero: NUM_WINDOWS=9, VOTE_WIDTH=3, 9x 0x008 -> class_out=3, class_votes=7.
//     A separate run with 4x 0x000 -> no_vote=1, class_out=0, class_votes=0.
//  5. Abort and collision: start after 2 results -> no class_valid; the next 4 results give a
//     fresh answer. start in the same cycle as result_valid -> the result is not counted.
//  6. Stray input: result_valid in IDLE or SCAN -> counters unchanged, and the final answer
//     equals the reference-model argmax.

Source files
------------

// File: rtl/class_vote_accumulator_pkg.sv
// Shared types and default sizing for the class vote accumulator.
// Holds the FSM state encoding and the per-image geometry defaults.
package class_vote_accumulator_pkg;

  localparam int DEFAULT_NUM_OUTPUT_CLASSES = 10;
  localparam int DEFAULT_NUM_WINDOWS        = 8325;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    SCAN    = 2'd2,
    DONE    = 2'd3
  } vote_state_t;

endpackage

// File: rtl/class_vote_accumulator_scan.sv
// Sequential argmax over the vote counters, one class per enabled cycle.
// A class replaces the current best only on a strictly greater count, so ties keep the lowest index.
module vote_argmax_scan
  import class_vote_accumulator_pkg::*;
#(
  parameter int IDX_WIDTH  = 4,
  parameter int VOTE_WIDTH = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  en,
  input  logic [IDX_WIDTH-1:0]  idx,
  input  logic [VOTE_WIDTH-1:0] vote,
  output logic [IDX_WIDTH-1:0]  best_idx,
  output logic [VOTE_WIDTH-1:0] best_votes,
  output logic                  any_nonzero
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      best_idx    <= '0;
      best_votes  <= '0;
      any_nonzero <= 1'b0;
    end else if (clear) begin
      best_idx    <= '0;
      best_votes  <= '0;
      any_nonzero <= 1'b0;
    end else if (en) begin
      if (vote > best_votes) begin
        best_idx   <= idx;
        best_votes <= vote;
      end
      if (vote != '0) begin
        any_nonzero <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/class_vote_accumulator.sv
// Per-image vote accumulator: counts saturating class votes over every window position,
// requests the next window from the core, then reports the argmax class once per image.
module class_vote_accumulator
  import class_vote_accumulator_pkg::*;
#(
  parameter int NUM_OUTPUT_CLASSES = DEFAULT_NUM_OUTPUT_CLASSES,
  parameter int NUM_WINDOWS        = DEFAULT_NUM_WINDOWS,
  parameter int VOTE_WIDTH         = $clog2(NUM_WINDOWS + 1),
  parameter int CLASS_IDX_WIDTH    = $clog2(NUM_OUTPUT_CLASSES)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [NUM_OUTPUT_CLASSES-1:0] result_in,
  input  logic                          result_valid,
  output logic                          slide,
  output logic                          busy,
  output logic [CLASS_IDX_WIDTH-1:0]    class_out,
  output logic [VOTE_WIDTH-1:0]         class_votes,
  output logic                          no_vote,
  output logic                          class_valid
);

  localparam int WIN_WIDTH = $clog2(NUM_WINDOWS + 1);
  localparam logic [WIN_WIDTH-1:0]       LAST_WIN = WIN_WIDTH'(NUM_WINDOWS - 1);
  localparam logic [CLASS_IDX_WIDTH-1:0] LAST_IDX = CLASS_IDX_WIDTH'(NUM_OUTPUT_CLASSES - 1);

  vote_state_t                state;
  logic [WIN_WIDTH-1:0]       win_cnt;
  logic [VOTE_WIDTH-1:0]      vote [NUM_OUTPUT_CLASSES];
  logic [CLASS_IDX_WIDTH-1:0] scan_idx;
  logic                       report;
  logic [VOTE_WIDTH-1:0]      scan_vote;
  logic                       scan_en;
  logic [CLASS_IDX_WIDTH-1:0] best_idx;
  logic [VOTE_WIDTH-1:0]      best_votes;
  logic                       any_nonzero;
  logic                       collect_hit;

  assign busy        = (state == COLLECT) || (state == SCAN);
  assign scan_en     = (state == SCAN) && !start;
  assign scan_vote   = vote[scan_idx];
  assign collect_hit = (state == COLLECT) && result_valid && !start;

  // Counters stick at all-ones; start always wins over a same-cycle result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_OUTPUT_CLASSES; i++) begin
        vote[i] <= '0;
      end
    end else if (start) begin
      for (int i = 0; i < NUM_OUTPUT_CLASSES; i++) begin
        vote[i] <= '0;
      end
    end else if (collect_hit) begin
      for (int i = 0; i < NUM_OUTPUT_CLASSES; i++) begin
        if (result_in[i] && (vote[i] != '1)) begin
          vote[i] <= vote[i] + VOTE_WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      win_cnt     <= '0;
      scan_idx    <= '0;
      report      <= 1'b0;
      slide       <= 1'b0;
      class_valid <= 1'b0;
      class_out   <= '0;
      class_votes <= '0;
      no_vote     <= 1'b0;
    end else begin
      slide       <= 1'b0;
      class_valid <= 1'b0;
      report      <= 1'b0;
      if (start) begin
        state       <= COLLECT;
        win_cnt     <= '0;
        scan_idx    <= '0;
        slide       <= 1'b1;
        class_out   <= '0;
        class_votes <= '0;
        no_vote     <= 1'b0;
      end else begin
        case (state)
          COLLECT: begin
            if (result_valid) begin
              win_cnt <= win_cnt + WIN_WIDTH'(1);
              if (win_cnt == LAST_WIN) begin
                state    <= SCAN;
                scan_idx <= '0;
              end else begin
                slide <= 1'b1;
              end
            end
          end
          SCAN: begin
            if (scan_idx == LAST_IDX) begin
              state  <= DONE;
              report <= 1'b1;
            end else begin
              scan_idx <= scan_idx + CLASS_IDX_WIDTH'(1);
            end
          end
          // The argmax registers settle on the last scan edge, so publish one cycle later.
          DONE: begin
            if (report) begin
              class_valid <= 1'b1;
              class_out   <= best_idx;
              class_votes <= best_votes;
              no_vote     <= ~any_nonzero;
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

  vote_argmax_scan #(
    .IDX_WIDTH  (CLASS_IDX_WIDTH),
    .VOTE_WIDTH (VOTE_WIDTH)
  ) u_argmax (
    .clk         (clk),
    .rst         (rst),
    .clear       (start),
    .en          (scan_en),
    .idx         (scan_idx),
    .vote        (scan_vote),
    .best_idx    (best_idx),
    .best_votes  (best_votes),
    .any_nonzero (any_nonzero)
  );

endmodule

// File: tb/tb_class_vote_accumulator.sv
// Directed bench for class_vote_accumulator: a 4-window and a 9-window instance, 3-bit votes.
// Expected values are hand-computed, plus a small argmax model for the stray-input run.
module tb_class_vote_accumulator;

  localparam int NC  = 10;
  localparam int VW  = 3;
  localparam int CIW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          start9 = 1'b0;
  logic          result_valid = 1'b0;
  logic [NC-1:0] result_in = '0;

  logic           slide, busy, no_vote, class_valid;
  logic [CIW-1:0] class_out;
  logic [VW-1:0]  class_votes;
  logic           slide9, busy9, no_vote9, class_valid9;
  logic [CIW-1:0] class_out9;
  logic [VW-1:0]  class_votes9;

  int total = 0;
  int bad = 0;
  int valid_cnt = 0;
  int valid9_cnt = 0;
  int slide_cnt = 0;
  int overlap_cnt = 0;

  class_vote_accumulator #(
    .NUM_OUTPUT_CLASSES (NC),
    .NUM_WINDOWS        (4),
    .VOTE_WIDTH         (VW),
    .CLASS_IDX_WIDTH    (CIW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .result_in    (result_in),
    .result_valid (result_valid),
    .slide        (slide),
    .busy         (busy),
    .class_out    (class_out),
    .class_votes  (class_votes),
    .no_vote      (no_vote),
    .class_valid  (class_valid)
  );

  class_vote_accumulator #(
    .NUM_OUTPUT_CLASSES (NC),
    .NUM_WINDOWS        (9),
    .VOTE_WIDTH         (VW),
    .CLASS_IDX_WIDTH    (CIW)
  ) dut9 (
    .clk          (clk),
    .rst          (rst),
    .start        (start9),
    .result_in    (result_in),
    .result_valid (result_valid),
    .slide        (slide9),
    .busy         (busy9),
    .class_out    (class_out9),
    .class_votes  (class_votes9),
    .no_vote      (no_vote9),
    .class_valid  (class_valid9)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (class_valid) valid_cnt++;
    if (class_valid9) valid9_cnt++;
    if (slide) slide_cnt++;
    if ((slide && class_valid) || (slide9 && class_valid9)) overlap_cnt++;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [NC-1:0] vec);
    result_in    = vec;
    result_valid = 1'b1;
    tick();
    result_valid = 1'b0;
    result_in    = '0;
  endtask

  task automatic send4(input logic [NC-1:0] v [4]);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(v[i]);
      if (i < 3) tick();
    end
  endtask

  task automatic do_start;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
  endtask

  task automatic wait_valid(input bit use9, output int n);
    n = -1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (use9 ? class_valid9 : class_valid) begin
        n = k;
        return;
      end
    end
  endtask

  function automatic void model(input logic [NC-1:0] v [4], output int idx, output int votes,
                                output int none);
    int cnt [NC];
    for (int c = 0; c < NC; c++) cnt[c] = 0;
    for (int w = 0; w < 4; w++)
      for (int c = 0; c < NC; c++)
        if (v[w][c] && cnt[c] < 7) cnt[c]++;
    idx = 0;
    votes = 0;
    none = 1;
    for (int c = 0; c < NC; c++) begin
      if (cnt[c] > votes) begin
        idx = c;
        votes = cnt[c];
      end
      if (cnt[c] != 0) none = 0;
    end
  endfunction

  initial begin
    logic [NC-1:0] seq [4];
    int n, s0, v0, m_idx, m_votes, m_none;

    // Reset state
    tick();
    tick();
    checkOutput("rst_slide", slide, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_class_out", class_out, 0);
    checkOutput("rst_class_votes", class_votes, 0);
    checkOutput("rst_no_vote", no_vote, 0);
    checkOutput("rst_class_valid", class_valid, 0);
    rst = 1'b1;
    tick();

    // Basic vote
    do_start();
    checkOutput("basic_busy", busy, 1);
    s0 = slide_cnt;
    v0 = valid_cnt;
    seq = '{10'h004, 10'h004, 10'h001, 10'h004};
    send4(seq);
    wait_valid(1'b0, n);
    checkOutput("basic_latency", n, 11);
    checkOutput("basic_slides", slide_cnt - s0, 3);
    checkOutput("basic_class_out", class_out, 2);
    checkOutput("basic_class_votes", class_votes, 3);
    checkOutput("basic_no_vote", no_vote, 0);
    tick();
    checkOutput("basic_valid_pulse", class_valid, 0);
    checkOutput("basic_hold", class_out, 2);
    checkOutput("basic_idle_busy", busy, 0);
    checkOutput("basic_valid_count", valid_cnt - v0, 1);

    // Asynchronous reset mid-collect, then a stray result in IDLE
    do_start();
    applyStimulus(10'h004);
    checkOutput("pre_rst_slide", slide, 1);
    rst = 1'b0;
    #1;
    checkOutput("async_rst_slide", slide, 0);
    checkOutput("async_rst_busy", busy, 0);
    checkOutput("async_rst_class_out", class_out, 0);
    checkOutput("async_rst_class_valid", class_valid, 0);
    tick();
    rst = 1'b1;
    v0 = valid_cnt;
    applyStimulus(10'h004);
    repeat (15) tick();
    checkOutput("post_rst_no_valid", valid_cnt - v0, 0);
    checkOutput("post_rst_busy", busy, 0);

    // Tie and multi-hot
    do_start();
    seq = '{10'h003, 10'h202, 10'h001, 10'h200};
    send4(seq);
    wait_valid(1'b0, n);
    checkOutput("tie_latency", n, 11);
    checkOutput("tie_class_out", class_out, 0);
    checkOutput("tie_class_votes", class_votes, 2);

    // Saturation on the 9-window instance
    start9 = 1'b1;
    tick();
    start9 = 1'b0;
    tick();
    for (int i = 0; i < 9; i++) begin
      applyStimulus(10'h008);
      if (i < 8) tick();
    end
    wait_valid(1'b1, n);
    checkOutput("sat_latency", n, 11);
    checkOutput("sat_class_out", class_out9, 3);
    checkOutput("sat_class_votes", class_votes9, 7);
    checkOutput("sat_no_vote", no_vote9, 0);

    // All-zero windows
    do_start();
    checkOutput("start_clears_votes", class_votes, 0);
    seq = '{10'h000, 10'h000, 10'h000, 10'h000};
    send4(seq);
    wait_valid(1'b0, n);
    checkOutput("zero_latency", n, 11);
    checkOutput("zero_no_vote", no_vote, 1);
    checkOutput("zero_class_out", class_out, 0);
    checkOutput("zero_class_votes", class_votes, 0);

    // Abort after two results
    do_start();
    v0 = valid_cnt;
    applyStimulus(10'h010);
    tick();
    applyStimulus(10'h010);
    tick();
    do_start();
    seq = '{10'h020, 10'h020, 10'h010, 10'h000};
    send4(seq);
    wait_valid(1'b0, n);
    checkOutput("abort_latency", n, 11);
    checkOutput("abort_class_out", class_out, 5);
    checkOutput("abort_class_votes", class_votes, 2);
    tick();
    checkOutput("abort_valid_count", valid_cnt - v0, 1);

    // start and result_valid together: the result is dropped
    start = 1'b1;
    result_valid = 1'b1;
    result_in = 10'h002;
    tick();
    start = 1'b0;
    result_valid = 1'b0;
    result_in = '0;
    tick();
    seq = '{10'h100, 10'h100, 10'h002, 10'h000};
    send4(seq);
    wait_valid(1'b0, n);
    checkOutput("collide_latency", n, 11);
    checkOutput("collide_class_out", class_out, 8);
    checkOutput("collide_class_votes", class_votes, 2);

    // Stray results during SCAN
    do_start();
    seq = '{10'h001, 10'h200, 10'h001, 10'h000};
    send4(seq);
    applyStimulus(10'h200);
    applyStimulus(10'h200);
    applyStimulus(10'h200);
    wait_valid(1'b0, n);
    model(seq, m_idx, m_votes, m_none);
    checkOutput("stray_latency", n, 8);
    checkOutput("stray_class_out", class_out, m_idx);
    checkOutput("stray_class_votes", class_votes, m_votes);
    checkOutput("stray_no_vote", no_vote, m_none);

    tick();
    checkOutput("slide_with_valid", overlap_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
